// File: rtl/lab4_count_ctrl.sv
// Run/pause/clear controller for a two-digit BCD up-counter with active-low 7-segment drive.
// Button edges become one-cycle commands; a prescaler paces the count while the FSM is in RUN.
module lab4_count_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned MAX_COUNT = 59,
  parameter bit          WRAP      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  output logic       count_en,
  output logic [7:0] count_bcd,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [1:0] state,
  output logic       done
);

  localparam int unsigned      PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]       MAX_BCD    = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t        st;
  logic [PW-1:0] presc;
  logic          start_q, stop_q, clear_q;
  logic          cmd_start, cmd_stop, cmd_clear;
  logic          go, tick, at_max, finish;
  logic [7:0]    count_inc;

  // Rising-edge commands; stop outranks start so a simultaneous press pauses.
  assign cmd_start = start_btn & ~start_q;
  assign cmd_stop  = stop_btn  & ~stop_q;
  assign cmd_clear = clear_btn & ~clear_q;
  assign go        = cmd_start & ~cmd_stop;

  assign tick   = (st == RUN) && (presc == PRESC_LAST);
  assign at_max = (count_bcd == MAX_BCD);
  assign finish = tick & at_max & ~WRAP;

  assign count_inc = (count_bcd[3:0] == 4'd9) ? {count_bcd[7:4] + 4'd1, 4'd0}
                                              : {count_bcd[7:4], count_bcd[3:0] + 4'd1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      presc     <= '0;
      count_bcd <= 8'h00;
      count_en  <= 1'b0;
      done      <= 1'b0;
      start_q   <= 1'b1;
      stop_q    <= 1'b1;
      clear_q   <= 1'b1;
    end else begin
      start_q  <= start_btn;
      stop_q   <= stop_btn;
      clear_q  <= clear_btn;
      count_en <= 1'b0;
      done     <= 1'b0;
      if (cmd_clear) begin
        st        <= IDLE;
        presc     <= '0;
        count_bcd <= 8'h00;
      end else begin
        unique case (st)
          IDLE: begin
            presc <= '0;
            if (go) st <= RUN;
          end
          RUN: begin
            if (tick) begin
              presc <= '0;
              if (!at_max) begin
                count_bcd <= count_inc;
                count_en  <= 1'b1;
              end else if (WRAP) begin
                count_bcd <= 8'h00;
                count_en  <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
            // Reaching the terminal value wins over a same-cycle pause.
            if (finish) begin
              st   <= DONE;
              done <= 1'b1;
            end else if (cmd_stop) begin
              st <= PAUSE;
            end
          end
          PAUSE: begin
            if (go) st <= RUN;
          end
          DONE: begin
            presc <= '0;
            if (go) begin
              count_bcd <= 8'h00;
              st        <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign hex0  = seg7(count_bcd[3:0]);
  assign hex1  = seg7(count_bcd[7:4]);
  assign state = st;

endmodule
